// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared defaults, iteration count and FSM state type for the sqrt arbiter
package sqrt_pkg;
    localparam int WIDTH_DEF = 128;
    localparam int FBITS_DEF = 64;
    localparam int ITER      = (WIDTH_DEF + FBITS_DEF) / 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_RESP
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts one past the last grant
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_idx_o
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end
endmodule

// File: rtl/sqrt_core.sv
// rtl/sqrt_core.sv - iterative fixed-point square root, two radicand bits per cycle, no reset
module sqrt_core #(
    parameter int WIDTH = 128,
    parameter int FBITS = 64
) (
    input  logic             clk,
    input  logic             start_i,
    input  logic [WIDTH-1:0] rad_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] root_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int XW   = WIDTH + FBITS;
    localparam int ITER = XW / 2;
    localparam int RW   = ITER + 2;
    localparam int CW   = $clog2(ITER + 1);

    logic [XW-1:0]   x_q;
    logic [ITER-1:0] q_q;
    logic [RW-1:0]   r_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            valid_q;
    logic [RW-1:0]   r_sh;
    logic [RW-1:0]   trial;

    assign r_sh  = {r_q[RW-3:0], x_q[XW-1 -: 2]};
    assign trial = {q_q, 2'b01};

    // The last iteration and the busy->valid handoff share one edge.
    always_ff @(posedge clk) begin
        if (start_i) begin
            x_q     <= {rad_i, {FBITS{1'b0}}};
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= CW'(ITER);
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else if (busy_q) begin
            x_q   <= x_q << 2;
            cnt_q <= cnt_q - 1'b1;
            if (r_sh >= trial) begin
                r_q <= r_sh - trial;
                q_q <= {q_q[ITER-2:0], 1'b1};
            end else begin
                r_q <= r_sh;
                q_q <= {q_q[ITER-2:0], 1'b0};
            end
            if (cnt_q == CW'(1)) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign root_o  = WIDTH'(q_q);
    assign rem_o   = WIDTH'(r_q);
endmodule

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - serialises NREQ requesters onto one sqrt core; SQRT_ARB_ZERO_BYPASS_EN short-cuts zero radicands
module sqrt_arbiter
    import sqrt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FBITS = FBITS_DEF,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_rad,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [WIDTH-1:0]        resp_root,
    output logic [WIDTH-1:0]        resp_rem,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);

    arb_state_e       state_q;
    logic [IW-1:0]    last_q;
    logic [IW-1:0]    id_q;
    logic [WIDTH-1:0] rad_q;
    logic [WIDTH-1:0] root_q;
    logic [WIDTH-1:0] rem_q;
    logic             start_q;
    logic             resp_valid_q;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_rad;
    logic             core_busy;
    logic             core_valid;
    logic [WIDTH-1:0] core_root;
    logic [WIDTH-1:0] core_rem;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    sqrt_core #(.WIDTH(WIDTH), .FBITS(FBITS)) u_core (
        .clk     (clk),
        .start_i (start_q),
        .rad_i   (rad_q),
        .busy_o  (core_busy),
        .valid_o (core_valid),
        .root_o  (core_root),
        .rem_o   (core_rem)
    );

    // The core keeps running through our reset, so a grant must also wait for it to drain.
    assign req_ready = (rst_n && state_q == ST_IDLE && !core_busy) ? gnt : '0;

    always_comb begin
        gnt_rad = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) gnt_rad = req_rad[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_q       <= IW'(NREQ - 1);
            id_q         <= '0;
            rad_q        <= '0;
            root_q       <= '0;
            rem_q        <= '0;
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_ready) begin
                        last_q <= gnt_idx;
                        id_q   <= gnt_idx;
                        rad_q  <= gnt_rad;
`ifdef SQRT_ARB_ZERO_BYPASS_EN
                        if (gnt_rad == '0) begin
                            root_q       <= '0;
                            rem_q        <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= ST_LAUNCH;
                        end
`else
                        start_q <= 1'b1;
                        state_q <= ST_LAUNCH;
`endif
                    end
                end
                ST_LAUNCH: state_q <= ST_RUN;
                ST_RUN: begin
                    if (core_valid && !core_busy) begin
                        root_q       <= core_root;
                        rem_q        <= core_rem;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_root  = root_q;
    assign resp_rem   = rem_q;
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - directed table and corner-sequence bench for sqrt_arbiter
module tb_sqrt_arbiter;
    localparam int W   = 128;
    localparam int N   = 4;
    localparam int LAT = 99;
`ifdef SQRT_ARB_ZERO_BYPASS_EN
    localparam int LAT0 = 1;
`else
    localparam int LAT0 = 99;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_rad = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_root;
    logic [W-1:0]   resp_rem;
    logic           busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         k;
        logic [W-1:0] rad;
        logic [W-1:0] root;
        logic [W-1:0] rem;
        int         lat;
    } vec_t;
    vec_t vecs[7];

    sqrt_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rad    (req_rad),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_root  (resp_root),
        .resp_rem   (resp_rem),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(input int k, inout int n, input int limit);
        while (req_ready[k] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_resp(inout int n, input int limit);
        while (resp_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic run_one(input int k, input logic [W-1:0] rad, input logic [W-1:0] root,
                           input logic [W-1:0] rem, input int lat, input string tag);
        int n;
        logic [255:0] sq;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_rad[k*W +: W] = rad;
        #1;
        n = 0;
        wait_grant(k, n, 300);
        chk({tag, "_grant"}, req_ready, 256'(4'b0001 << k));
        @(negedge clk);
        req_valid[k] = 1'b0;
        #1;
        n = 1;
        wait_resp(n, 400);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_root"}, resp_root, root);
        chk({tag, "_rem"}, resp_rem, rem);
        chk({tag, "_id"}, resp_id, k);
        sq = 256'(resp_root) * 256'(resp_root) + 256'(resp_rem);
        chk({tag, "_square"}, sq, {64'b0, rad, 64'b0});
        tick();
    endtask

    initial begin
        int n;
        int ng;
        int nr;
        int bad;
        int order[8];
        logic [W-1:0] rr_root[4];
        logic [W-1:0] snap_root;
        logic [W-1:0] snap_rem;
        logic [1:0]   snap_id;

        vecs[0] = '{0, 128'd1 << 66, 128'd1 << 65, 128'd0, LAT};
        vecs[1] = '{1, 128'd1 << 64, 128'd1 << 64, 128'd0, LAT};
        vecs[2] = '{2, 128'd9 << 64, 128'd3 << 64, 128'd0, LAT};
        vecs[3] = '{3, 128'd1, 128'd1 << 32, 128'd0, LAT};
        vecs[4] = '{1, 128'd1 << 62, 128'd1 << 63, 128'd0, LAT};
        vecs[5] = '{2, {W{1'b1}}, (128'd1 << 96) - 128'd1,
                    (128'd1 << 97) - (128'd1 << 64) - 128'd1, LAT};
        vecs[6] = '{3, 128'd0, 128'd0, 128'd0, LAT0};

        req_valid = 4'b1111;
        repeat (4) tick();
        chk("reset_req_ready", req_ready, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_resp_id", resp_id, 0);
        chk("reset_resp_root", resp_root, 0);
        chk("reset_resp_rem", resp_rem, 0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i].k, vecs[i].rad, vecs[i].root, vecs[i].rem, vecs[i].lat,
                    $sformatf("vec%0d", i));
        end

        // all four requesting continuously: rotation 0,1,2,3,0
        rr_root[0] = 128'd1 << 65;
        rr_root[1] = 128'd3 << 64;
        rr_root[2] = 128'd1 << 64;
        rr_root[3] = 128'd1 << 63;
        @(negedge clk);
        req_rad[0*W +: W] = 128'd1 << 66;
        req_rad[1*W +: W] = 128'd9 << 64;
        req_rad[2*W +: W] = 128'd1 << 64;
        req_rad[3*W +: W] = 128'd1 << 62;
        req_valid = 4'b1111;
        #1;
        ng = 0; nr = 0; n = 0; bad = 0;
        while (nr < 5 && n < 800) begin
            if (req_ready != '0) begin
                if ($countones(req_ready) != 1) bad++;
                for (int j = 0; j < N; j++) if (req_ready[j] && ng < 8) order[ng] = j;
                ng++;
            end
            if (resp_valid) begin
                chk($sformatf("rr_root%0d", nr), resp_root, rr_root[resp_id]);
                nr++;
            end
            tick();
            n++;
        end
        req_valid = '0;
        chk("rr_responses", nr, 5);
        chk("rr_grants", ng, 5);
        chk("rr_onehot_errors", bad, 0);
        for (int j = 0; j < 5; j++) chk($sformatf("rr_order%0d", j), order[j], j % 4);
        tick();
        tick();

        // consumer stall: outputs held, no grant until one cycle after the handshake
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_rad[0*W +: W] = 128'd1 << 64;
        #1;
        n = 0;
        wait_grant(0, n, 300);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b1;
        req_rad[2*W +: W] = 128'd9 << 64;
        #1;
        n = 1;
        wait_resp(n, 400);
        chk("stall_latency", n, LAT);
        snap_root = resp_root;
        snap_rem = resp_rem;
        snap_id = resp_id;
        bad = 0; ng = 0;
        repeat (20) begin
            tick();
            if (resp_valid !== 1'b1 || resp_root !== snap_root || resp_rem !== snap_rem ||
                resp_id !== snap_id) bad++;
            if (req_ready != '0) ng++;
        end
        chk("stall_unstable_cycles", bad, 0);
        chk("stall_ready_pulses", ng, 0);
        chk("stall_root", snap_root, 128'd1 << 64);
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        chk("hs_cycle_ready", req_ready, 0);
        chk("hs_cycle_valid", resp_valid, 1);
        tick();
        chk("post_hs_grant", req_ready, 4'b0100);
        chk("post_hs_valid", resp_valid, 0);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        n = 1;
        wait_resp(n, 400);
        chk("post_hs_root", resp_root, 128'd3 << 64);
        chk("post_hs_id", resp_id, 2);
        tick();

        // a one-cycle request during RUN must be dropped silently
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_rad[0*W +: W] = 128'd1 << 66;
        #1;
        n = 0;
        wait_grant(0, n, 300);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        n = 1; bad = 0;
        while (resp_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
            if (n == 30) begin
                req_valid[2] = 1'b1;
                req_rad[2*W +: W] = 128'd1 << 64;
            end
            if (n == 31) req_valid[2] = 1'b0;
            if (req_ready != '0) bad++;
        end
        chk("blip_latency", n, LAT);
        chk("blip_grants_during_run", bad, 0);
        chk("blip_id", resp_id, 0);
        chk("blip_root", resp_root, 128'd1 << 65);
        bad = 0;
        repeat (120) begin
            tick();
            if (resp_valid || req_ready != '0) bad++;
        end
        chk("blip_stray_activity", bad, 0);

        // reset in mid-RUN: result dropped, next grant waits for the core to drain
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_rad[0*W +: W] = 128'd1 << 66;
        #1;
        n = 0;
        wait_grant(0, n, 300);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_rad[1*W +: W] = 128'd9 << 64;
        #1;
        n = 1;
        repeat (51) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_root", resp_root, 0);
        chk("midrst_rem", resp_rem, 0);
        chk("midrst_id", resp_id, 0);
        tick(); n++;
        tick(); n++;
        rst_n = 1'b1;
        wait_grant(1, n, 300);
        chk("midrst_regrant_cycle", n, 98);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        n = 1;
        wait_resp(n, 400);
        chk("midrst_latency", n, LAT);
        chk("midrst_after_root", resp_root, 128'd3 << 64);
        chk("midrst_after_id", resp_id, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
